// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU arbiter slice: operation encodings,
// NZCV bit positions and the response-slot state.
package alu_pkg;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_OR  = 2'b11
  } alu_ctrl_e;

  localparam int NZCV_N = 3;
  localparam int NZCV_Z = 2;
  localparam int NZCV_C = 1;
  localparam int NZCV_V = 0;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

endpackage

// File: rtl/alu_arbiter_if.sv
// Signal bundle for the two-requester ALU arbiter: the requester/consumer side
// is the master, the arbiter is the slave.
interface alu_arbiter_if #(
  parameter int N = 32
);

  logic [1:0]   req_valid;
  logic [1:0]   req_ready;
  logic [N-1:0] a0;
  logic [N-1:0] b0;
  logic [1:0]   ctrl0;
  logic [N-1:0] a1;
  logic [N-1:0] b1;
  logic [1:0]   ctrl1;
  logic         rsp_valid;
  logic         rsp_ready;
  logic         rsp_id;
  logic [N-1:0] result;
  logic [3:0]   nzcv;
  logic [3:0]   flags;

  modport master (
    output req_valid, a0, b0, ctrl0, a1, b1, ctrl1, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, result, nzcv, flags
  );

  modport slave (
    input  req_valid, a0, b0, ctrl0, a1, b1, ctrl1, rsp_ready,
    output req_ready, rsp_valid, rsp_id, result, nzcv, flags
  );

endinterface

// File: rtl/alu_nzcv.sv
// Combinational N-bit ALU (ADD/SUB/AND/OR) producing a result and NZCV flags.
module alu_nzcv
  import alu_pkg::*;
#(
  parameter int N = 32
) (
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  input  alu_ctrl_e    i_ctrl,
  output logic [N-1:0] o_result,
  output logic [3:0]   o_nzcv
);

  logic [N:0] w_sum;
  logic [N:0] w_dif;
  logic       w_c;
  logic       w_v;

  // Subtraction as a + ~b + 1: the carry-out is the "no borrow" indication.
  assign w_sum = {1'b0, i_a} + {1'b0, i_b};
  assign w_dif = {1'b0, i_a} + {1'b0, ~i_b} + {{N{1'b0}}, 1'b1};

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    o_result = '0;
    w_c      = 1'b0;
    w_v      = 1'b0;
    unique case (i_ctrl)
      ALU_ADD: begin
        o_result = w_sum[N-1:0];
        w_c      = w_sum[N];
        w_v      = (i_a[N-1] == i_b[N-1]) && (w_sum[N-1] != i_a[N-1]);
      end
      ALU_SUB: begin
        o_result = w_dif[N-1:0];
        w_c      = w_dif[N];
        w_v      = (i_a[N-1] != i_b[N-1]) && (w_dif[N-1] != i_a[N-1]);
      end
      ALU_AND: o_result = i_a & i_b;
      ALU_OR:  o_result = i_a | i_b;
      default: o_result = '0;
    endcase
  end

  always_comb begin
    o_nzcv         = '0;
    o_nzcv[NZCV_N] = o_result[N-1];
    o_nzcv[NZCV_Z] = (o_result == '0);
    o_nzcv[NZCV_C] = w_c;
    o_nzcv[NZCV_V] = w_v;
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one alu_nzcv between two valid/ready requesters,
// with a single-entry registered response slot and an architectural NZCV register.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [1:0]   i_req_valid,
  output logic [1:0]   o_req_ready,
  input  logic [N-1:0] i_a0,
  input  logic [N-1:0] i_b0,
  input  logic [1:0]   i_ctrl0,
  input  logic [N-1:0] i_a1,
  input  logic [N-1:0] i_b1,
  input  logic [1:0]   i_ctrl1,
  output logic         o_rsp_valid,
  input  logic         i_rsp_ready,
  output logic         o_rsp_id,
  output logic [N-1:0] o_result,
  output logic [3:0]   o_nzcv,
  output logic [3:0]   o_flags
);

  slot_state_e  r_state;
  slot_state_e  w_state_nxt;
  logic         r_prio;
  logic         w_slot_free;
  logic         w_accept;
  logic         w_gnt_id;
  logic         w_rsp_hs;
  logic [N-1:0] w_alu_a;
  logic [N-1:0] w_alu_b;
  alu_ctrl_e    w_alu_ctrl;
  logic [N-1:0] w_alu_result;
  logic [3:0]   w_alu_nzcv;
  logic [N-1:0] r_result;
  logic [3:0]   r_nzcv;
  logic         r_rsp_id;
  logic [3:0]   r_flags;

  // Slot FSM: state register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples pre-edge values regardless of block ordering.
      r_state <= SLOT_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Slot FSM: next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      SLOT_EMPTY: if (w_accept) w_state_nxt = SLOT_FULL;
      SLOT_FULL:  if (i_rsp_ready && !w_accept) w_state_nxt = SLOT_EMPTY;
      default:    w_state_nxt = SLOT_EMPTY;
    endcase
  end

  // Slot FSM: outputs, including the grant that only exists while the slot is free.
  always_comb begin
    o_rsp_valid = (r_state == SLOT_FULL);
    w_slot_free = (r_state == SLOT_EMPTY) || i_rsp_ready;
    o_req_ready = 2'b00;
    if (w_slot_free) begin
      unique case (i_req_valid)
        2'b01:   o_req_ready = 2'b01;
        2'b10:   o_req_ready = 2'b10;
        2'b11:   o_req_ready = r_prio ? 2'b10 : 2'b01;
        default: o_req_ready = 2'b00;
      endcase
    end
  end

  assign w_accept = |(i_req_valid & o_req_ready);
  assign w_gnt_id = o_req_ready[1];
  assign w_rsp_hs = o_rsp_valid && i_rsp_ready;

  assign w_alu_a    = w_gnt_id ? i_a1 : i_a0;
  assign w_alu_b    = w_gnt_id ? i_b1 : i_b0;
  assign w_alu_ctrl = w_gnt_id ? alu_ctrl_e'(i_ctrl1) : alu_ctrl_e'(i_ctrl0);

  alu_nzcv #(
    .N (N)
  ) u_alu (
    .i_a      (w_alu_a),
    .i_b      (w_alu_b),
    .i_ctrl   (w_alu_ctrl),
    .o_result (w_alu_result),
    .o_nzcv   (w_alu_nzcv)
  );

  // Round-robin pointer hands priority to the other requester after each grant.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_prio <= 1'b0;
    end else if (w_accept) begin
      r_prio <= ~w_gnt_id;
    end
  end

  // Response slot payload only loads on acceptance, so it holds under backpressure.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_result <= '0;
      r_nzcv   <= '0;
      r_rsp_id <= 1'b0;
    end else if (w_accept) begin
      r_result <= w_alu_result;
      r_nzcv   <= w_alu_nzcv;
      r_rsp_id <= w_gnt_id;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_flags <= '0;
    end else if (w_rsp_hs) begin
      r_flags <= r_nzcv;
    end
  end

  assign o_result = r_result;
  assign o_nzcv   = r_nzcv;
  assign o_rsp_id = r_rsp_id;
  assign o_flags  = r_flags;

endmodule
